// File: rtl/rca4_nibble_sequencer.sv
// rca4_nibble_sequencer: multi-cycle wide adder built around one external
// 4-bit ripple-carry adder. Operands are fed to the RCA one nibble per cycle,
// LSB nibble first, with the previous nibble's carry-out chained back as c_i.
// Optional macro RCA4_SEQ_SUB_EN adds a 'sub' input for a - b (two's complement).
module rca4_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef RCA4_SEQ_SUB_EN
    input  logic                 sub,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic [3:0]           rca_x,
    output logic [3:0]           rca_y,
    output logic                 rca_ci,
    input  logic [3:0]           rca_s,
    input  logic                 rca_co,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               w_last;
    logic [IDX_W+1:0]   w_base;
    logic [W-1:0]       w_b_in;
    logic               w_c_in;

    assign w_last = (r_idx == IDX_W'(NIBBLES - 1));
    // Bit offset of the active nibble (idx * 4)
    assign w_base = {r_idx, 2'b00};

`ifdef RCA4_SEQ_SUB_EN
    // Subtraction as a + ~b + 1; cout=1 then means no borrow
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : cin;
`else
    assign w_b_in = b;
    assign w_c_in = cin;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_next = S_RUN;
            S_RUN:  if (w_last)    w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default:               w_next = S_IDLE;
        endcase
    end

    // Operand capture, nibble index and per-nibble result collection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_c_in;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[w_base +: 4] <= rca_s;
                    r_carry            <= rca_co;
                    if (w_last) begin
                        r_cout <= rca_co;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags and RCA drive; RCA inputs are held at zero outside RUN
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rca_x     = 4'h0;
        rca_y     = 4'h0;
        rca_ci    = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_RUN: begin
                rca_x  = r_a[w_base +: 4];
                rca_y  = r_b[w_base +: 4];
                rca_ci = r_carry;
            end
            S_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
